lsu_port: RTL and testbench

LSU_PORT -- requirements
Module: lsu_port

---
 rtl/lsu_port_pkg.sv | 21 ++
 rtl/lsu_port_if.sv | 40 ++++
 rtl/lsu_align_chk.sv | 20 ++
 rtl/lsu_port.sv | 121 ++++++++++++
 tb/tb_lsu_port.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_port_pkg.sv
// Shared types and constants for the load/store port: FSM encoding, access
// size codes and the value mem_ctrl rests at when no access is in flight.
package lsu_port_pkg;

  localparam int unsigned CTRL_W = 3;
  localparam int unsigned SIZE_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
  localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
  localparam logic [SIZE_W-1:0] SZ_W = 2'd2;
  localparam logic [SIZE_W-1:0] SZ_D = 2'd3;

  localparam logic [CTRL_W-1:0] MEM_CTRL_IDLE = 3'b011;

endpackage

// File: rtl/lsu_port_if.sv
// Pipeline request/response handshake plus data-memory port of the LSU.
// slave: the LSU itself; master: the pipeline and memory surrounding it.
interface lsu_port_if
  import lsu_port_pkg::*;
#(
  parameter int unsigned bits       = 64,
  parameter int unsigned addr_width = 10
);

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [CTRL_W-1:0]     req_ctrl;
  logic [addr_width-1:0] req_addr;
  logic [bits-1:0]       req_wdata;

  logic                  resp_valid;
  logic                  resp_ready;
  logic [bits-1:0]       resp_rdata;
  logic                  resp_err;

  logic [CTRL_W-1:0]     mem_ctrl;
  logic [addr_width-1:0] mem_addr;
  logic [bits-1:0]       mem_wdata;
  logic                  mem_we;
  logic [bits-1:0]       mem_rdata;

  modport slave (
    input  req_valid, req_we, req_ctrl, req_addr, req_wdata, resp_ready, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_ctrl, mem_addr, mem_wdata, mem_we
  );

  modport master (
    output req_valid, req_we, req_ctrl, req_addr, req_wdata, resp_ready, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_ctrl, mem_addr, mem_wdata, mem_we
  );

endinterface

// File: rtl/lsu_align_chk.sv
// Flags an access whose address is not a multiple of its size; bytes never are.
module lsu_align_chk
  import lsu_port_pkg::*;
(
  input  logic [SIZE_W-1:0] size,
  input  logic [2:0]        addr_lo,
  output logic              misaligned_c
);

  always_comb begin
    misaligned_c = 1'b0;
    unique case (size)
      SZ_B:    misaligned_c = 1'b0;
      SZ_H:    misaligned_c = addr_lo[0];
      SZ_W:    misaligned_c = |addr_lo[1:0];
      default: misaligned_c = |addr_lo;
    endcase
  end

endmodule

// File: rtl/lsu_port.sv
// Single-outstanding load/store port: accept -> one memory cycle -> response.
// Define LSU_MISALIGN_TRAP_EN to reject misaligned accesses without touching memory.
module lsu_port
  import lsu_port_pkg::*;
#(
  parameter int unsigned bits       = 64,
  parameter int unsigned addr_width = 10
) (
  input  logic       clk,
  input  logic       async_reset_n,
  lsu_port_if.slave  bus
);

`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit trap_en = 1'b1;
`else
  localparam bit trap_en = 1'b0;
`endif

  state_t state_q, state_d;

  logic                  misaligned_c;
  logic                  trap_c;
  logic                  req_ready_c;
  logic                  accept_c;

  logic                  mem_we_q,    mem_we_d;
  logic [CTRL_W-1:0]     mem_ctrl_q,  mem_ctrl_d;
  logic [addr_width-1:0] mem_addr_q,  mem_addr_d;
  logic [bits-1:0]       mem_wdata_q, mem_wdata_d;
  logic [bits-1:0]       rdata_q,     rdata_d;
  logic                  err_q,       err_d;

  lsu_align_chk u_align_chk (
    .size         (bus.req_ctrl[SIZE_W-1:0]),
    .addr_lo      (bus.req_addr[2:0]),
    .misaligned_c (misaligned_c)
  );

  assign trap_c      = trap_en && misaligned_c;
  assign req_ready_c = (state_q == IDLE) || ((state_q == RESP) && bus.resp_ready);
  assign accept_c    = bus.req_valid && req_ready_c;

  // State register
  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) state_q <= IDLE;
    else                state_q <= state_d;
  end

  // Next state; a trapped request bypasses the memory cycle
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (accept_c) state_d = trap_c ? RESP : ISSUE;
      ISSUE: state_d = RESP;
      RESP:  if (bus.resp_ready) state_d = accept_c ? (trap_c ? RESP : ISSUE) : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered memory and response outputs
  always_comb begin
    mem_we_d    = 1'b0;
    mem_ctrl_d  = MEM_CTRL_IDLE;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    rdata_d     = rdata_q;
    err_d       = err_q;

    if ((state_q == RESP) && bus.resp_ready) begin
      rdata_d = '0;
      err_d   = 1'b0;
    end

    // The mem registers hold the latched request for the ISSUE cycle
    if (state_q == ISSUE) begin
      rdata_d = mem_we_q ? '0 : bus.mem_rdata;
      err_d   = 1'b0;
    end

    if (accept_c) begin
      if (trap_c) begin
        rdata_d = '0;
        err_d   = 1'b1;
      end else begin
        mem_we_d    = bus.req_we;
        mem_ctrl_d  = bus.req_ctrl;
        mem_addr_d  = bus.req_addr;
        mem_wdata_d = bus.req_wdata;
      end
    end
  end

  always_ff @(posedge clk or negedge async_reset_n) begin
    if (!async_reset_n) begin
      mem_we_q    <= 1'b0;
      mem_ctrl_q  <= MEM_CTRL_IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      mem_we_q    <= mem_we_d;
      mem_ctrl_q  <= mem_ctrl_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
    end
  end

  assign bus.req_ready  = req_ready_c;
  assign bus.resp_valid = (state_q == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_we     = mem_we_q;
  assign bus.mem_ctrl   = mem_ctrl_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_lsu_port.sv
// Directed bench for lsu_port with a byte-addressed data memory model that
// returns sign/zero-extended read data. Honours LSU_MISALIGN_TRAP_EN.
module tb_lsu_port;
  import lsu_port_pkg::*;

  localparam int unsigned BITS = 64;
  localparam int unsigned AW   = 10;

  logic clk = 1'b0;
  logic async_reset_n;
  logic clear_mem;

  always #5 clk = ~clk;

  lsu_port_if #(.bits(BITS), .addr_width(AW)) bus ();

  lsu_port #(.bits(BITS), .addr_width(AW)) dut (
    .clk           (clk),
    .async_reset_n (async_reset_n),
    .bus           (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [0:1023];

  // Memory writes: strobe sampled on the rising edge
  always @(posedge clk) begin
    if (clear_mem) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
    end else if (bus.mem_we) begin
      for (int i = 0; i < 8; i++)
        if (i < (1 << bus.mem_ctrl[1:0]))
          mem[bus.mem_addr + 10'(i)] <= bus.mem_wdata[8*i +: 8];
    end
  end

  // Combinational, already-extended read data
  always_comb begin
    logic [63:0] raw;
    raw = '0;
    for (int i = 0; i < 8; i++)
      if (i < (1 << bus.mem_ctrl[1:0]))
        raw[8*i +: 8] = mem[bus.mem_addr + 10'(i)];
    if (!bus.mem_ctrl[2]) begin
      case (bus.mem_ctrl[1:0])
        2'd0:    raw = {{56{raw[7]}},  raw[7:0]};
        2'd1:    raw = {{48{raw[15]}}, raw[15:0]};
        2'd2:    raw = {{32{raw[31]}}, raw[31:0]};
        default: raw = raw;
      endcase
    end
    bus.mem_rdata = raw;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [2:0] ctrl, input logic [9:0] addr,
                       input logic [63:0] wdata);
    bus.req_valid = 1'b1;
    bus.req_we    = we;
    bus.req_ctrl  = ctrl;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
  endtask

  initial begin
    async_reset_n  = 1'b0;
    clear_mem      = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_ctrl   = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b0;
    tick();
    tick();

    chk("rst_req_ready",  64'(bus.req_ready),  64'd1);
    chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_resp_rdata", bus.resp_rdata,      64'd0);
    chk("rst_resp_err",   64'(bus.resp_err),   64'd0);
    chk("rst_mem_we",     64'(bus.mem_we),     64'd0);
    chk("rst_mem_ctrl",   64'(bus.mem_ctrl),   64'd3);
    chk("rst_mem_addr",   64'(bus.mem_addr),   64'd0);
    chk("rst_mem_wdata",  bus.mem_wdata,       64'd0);
    clear_mem = 1'b0;

    // Store word, request present as reset releases
    async_reset_n  = 1'b1;
    bus.resp_ready = 1'b1;
    drive(1'b1, 3'b010, 10'h010, 64'hDEAD_BEEF);
    #1 chk("st_req_ready", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("st_issue_we",    64'(bus.mem_we),     64'd1);
    chk("st_issue_ctrl",  64'(bus.mem_ctrl),   64'd2);
    chk("st_issue_addr",  64'(bus.mem_addr),   64'h10);
    chk("st_issue_wdata", bus.mem_wdata,       64'hDEAD_BEEF);
    chk("st_issue_rv",    64'(bus.resp_valid), 64'd0);
    chk("st_issue_rdy",   64'(bus.req_ready),  64'd0);
    tick();
    chk("st_resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("st_resp_err",   64'(bus.resp_err),   64'd0);
    chk("st_resp_rdata", bus.resp_rdata,      64'd0);
    chk("st_resp_we",    64'(bus.mem_we),     64'd0);
    chk("st_resp_ctrl",  64'(bus.mem_ctrl),   64'd3);

    // Back-to-back signed byte load while the store response retires
    drive(1'b0, 3'b000, 10'h010, 64'd0);
    #1 chk("b2b_req_ready", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("b2b_issue_rv",   64'(bus.resp_valid), 64'd0);
    chk("b2b_issue_we",   64'(bus.mem_we),     64'd0);
    chk("b2b_issue_ctrl", 64'(bus.mem_ctrl),   64'd0);
    chk("b2b_issue_addr", 64'(bus.mem_addr),   64'h10);
    tick();
    chk("lb_resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("lb_resp_rdata", bus.resp_rdata,      64'hFFFF_FFFF_FFFF_FFEF);
    chk("lb_resp_err",   64'(bus.resp_err),   64'd0);

    // Stall the response for five cycles with a new request waiting
    bus.resp_ready = 1'b0;
    drive(1'b0, 3'b100, 10'h010, 64'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_req_ready", 64'(bus.req_ready),  64'd0);
      chk("stall_resp_valid", 64'(bus.resp_valid), 64'd1);
      chk("stall_resp_rdata", bus.resp_rdata,      64'hFFFF_FFFF_FFFF_FFEF);
      chk("stall_mem_we",    64'(bus.mem_we),     64'd0);
      chk("stall_mem_ctrl",  64'(bus.mem_ctrl),   64'd3);
      tick();
    end
    bus.resp_ready = 1'b1;
    #1 chk("unstall_req_ready", 64'(bus.req_ready), 64'd1);
    tick();
    bus.req_valid = 1'b0;
    chk("lbu_issue_ctrl", 64'(bus.mem_ctrl),   64'd4);
    chk("lbu_issue_addr", 64'(bus.mem_addr),   64'h10);
    chk("lbu_issue_rv",   64'(bus.resp_valid), 64'd0);
    tick();
    chk("lbu_resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("lbu_resp_rdata", bus.resp_rdata,      64'h0000_0000_0000_00EF);
    chk("lbu_resp_err",   64'(bus.resp_err),   64'd0);
    tick();
    chk("idle_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("idle_req_ready",  64'(bus.req_ready),  64'd1);

    // Byte load at an odd address is never misaligned
    drive(1'b0, 3'b000, 10'h013, 64'd0);
    tick();
    bus.req_valid = 1'b0;
    chk("lb13_issue_addr", 64'(bus.mem_addr), 64'h13);
    chk("lb13_issue_ctrl", 64'(bus.mem_ctrl), 64'd0);
    tick();
    chk("lb13_resp_rdata", bus.resp_rdata,    64'hFFFF_FFFF_FFFF_FFDE);
    chk("lb13_resp_err",   64'(bus.resp_err), 64'd0);
    tick();

    // Misaligned word load at 0x13
    drive(1'b0, 3'b010, 10'h013, 64'd0);
    tick();
    bus.req_valid = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("mis_resp_err",   64'(bus.resp_err),   64'd1);
    chk("mis_resp_rdata", bus.resp_rdata,      64'd0);
    chk("mis_mem_we",     64'(bus.mem_we),     64'd0);
    chk("mis_mem_addr",   64'(bus.mem_addr),   64'd0);
    chk("mis_mem_ctrl",   64'(bus.mem_ctrl),   64'd3);
    tick();
`else
    chk("mis_issue_addr", 64'(bus.mem_addr),   64'h13);
    chk("mis_issue_ctrl", 64'(bus.mem_ctrl),   64'd2);
    chk("mis_issue_rv",   64'(bus.resp_valid), 64'd0);
    tick();
    chk("mis_resp_valid", 64'(bus.resp_valid), 64'd1);
    chk("mis_resp_rdata", bus.resp_rdata,      64'h0000_0000_0000_00DE);
    chk("mis_resp_err",   64'(bus.resp_err),   64'd0);
    tick();
`endif
    chk("mis_after_idle", 64'(bus.req_ready), 64'd1);

    // Reset asserted during a store's ISSUE cycle
    drive(1'b1, 3'b000, 10'h020, 64'h55);
    tick();
    bus.req_valid = 1'b0;
    chk("rst_mid_pre_we", 64'(bus.mem_we), 64'd1);
    async_reset_n = 1'b0;
    #1;
    chk("rst_mid_we",         64'(bus.mem_we),     64'd0);
    chk("rst_mid_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("rst_mid_req_ready",  64'(bus.req_ready),  64'd1);
    chk("rst_mid_mem_addr",   64'(bus.mem_addr),   64'd0);
    chk("rst_mid_mem_ctrl",   64'(bus.mem_ctrl),   64'd3);
    tick();
    chk("rst_mid_no_write", 64'(mem[32]), 64'd0);
    async_reset_n = 1'b1;
    tick();
    chk("post_rst_resp_valid", 64'(bus.resp_valid), 64'd0);
    chk("post_rst_req_ready",  64'(bus.req_ready),  64'd1);
    chk("post_rst_mem_we",     64'(bus.mem_we),     64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
